// File: rtl/score_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : score_digit_scanner
// Brief    : 3-digit multiplexed common-anode 7-seg driver for a packed-BCD
//            score, with leading-zero blanking and session high-score capture.
//            Optional macro SCORE_BLINK_EN blinks the display on a new record.
// Revision : 1.0 - initial release
// ============================================================================
module score_digit_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [11:0] Score,
  input  logic        game_over,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] high_score,
  output logic        new_record
);

  localparam int c_cnt_w = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 2 || REFRESH_DIV > (1 << 20) || BLINK_DIV < 2) begin : g_bad_param
    $error("score_digit_scanner: parameter out of range");
  end

  function automatic logic [6:0] f_bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic [c_cnt_w-1:0] r_refresh_cnt;
  logic [1:0]         r_digit_idx;
  logic [11:0]        r_shadow;
  logic               r_loaded;
  logic               r_go_prev;
  logic [6:0]         r_seg;
  logic [2:0]         r_an;
  logic [11:0]        r_high_score;
  logic               r_new_record;

  logic        w_tc;
  logic        w_shadow_load;
  logic [11:0] w_src;
  logic [3:0]  w_nib;
  logic        w_lz_blank;
  logic [6:0]  w_seg_next;
  logic [2:0]  w_an_next;
  logic [1:0]  w_idx_next;
  logic        w_score_valid;
  logic        w_update;
  logic        w_blink_off;

  assign w_tc          = (r_refresh_cnt == c_cnt_max);
  assign w_shadow_load = w_tc && (!r_loaded || r_digit_idx == 2'd2);
  // Before the first load the shadow is stale, so the very first digit uses live Score.
  assign w_src         = r_loaded ? r_shadow : Score;

  always_comb begin
    w_nib      = w_src[3:0];
    w_lz_blank = 1'b0;
    w_an_next  = 3'b110;
    w_idx_next = r_digit_idx;
    case (r_digit_idx)
      2'd1: begin
        w_nib      = w_src[7:4];
        w_lz_blank = (w_src[11:8] == 4'd0) && (w_src[7:4] == 4'd0);
        w_an_next  = 3'b101;
      end
      2'd2: begin
        w_nib      = w_src[11:8];
        w_lz_blank = (w_src[11:8] == 4'd0);
        w_an_next  = 3'b011;
      end
      default: ;
    endcase
    if (r_digit_idx == 2'd3) begin
      w_idx_next = 2'd0;
    end else if (w_tc) begin
      w_idx_next = (r_digit_idx == 2'd2) ? 2'd0 : r_digit_idx + 2'd1;
    end
    w_seg_next = w_lz_blank ? 7'h7F : f_bcd_to_seg(w_nib);
  end

  assign w_score_valid = (Score[3:0] <= 4'd9) && (Score[7:4] <= 4'd9) && (Score[11:8] <= 4'd9);
  assign w_update      = game_over && !r_go_prev && w_score_valid && (Score > r_high_score);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= 2'd0;
      r_shadow      <= 12'h000;
      r_loaded      <= 1'b0;
      r_go_prev     <= 1'b0;
      r_seg         <= 7'h7F;
      r_an          <= 3'b111;
      r_high_score  <= 12'h000;
      r_new_record  <= 1'b0;
    end else begin
      r_refresh_cnt <= w_tc ? '0 : r_refresh_cnt + 1'b1;
      r_digit_idx   <= w_idx_next;
      r_go_prev     <= game_over;
      r_new_record  <= w_update;
      if (w_update) begin
        r_high_score <= Score;
      end
      if (w_shadow_load) begin
        r_shadow <= Score;
        r_loaded <= 1'b1;
      end
      if (w_tc) begin
        r_seg <= w_seg_next;
        r_an  <= w_an_next;
      end
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int c_blink_w = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_blink_w-1:0] c_blink_max = c_blink_w'(BLINK_DIV - 1);

  logic [c_blink_w-1:0] r_blink_cnt;
  logic [2:0]           r_blink_half;
  logic                 r_blink_active;

  // Eight half-periods starting with an off half; a new record restarts the run.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_blink_cnt    <= '0;
      r_blink_half   <= 3'd0;
      r_blink_active <= 1'b0;
    end else if (w_update) begin
      r_blink_cnt    <= '0;
      r_blink_half   <= 3'd0;
      r_blink_active <= 1'b1;
    end else if (r_blink_active) begin
      if (r_blink_cnt == c_blink_max) begin
        r_blink_cnt  <= '0;
        r_blink_half <= r_blink_half + 3'd1;
        if (r_blink_half == 3'd7) begin
          r_blink_active <= 1'b0;
        end
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_blink_off = r_blink_active && !r_blink_half[0];
`else
  assign w_blink_off = 1'b0;
`endif

  assign seg        = r_seg;
  assign an         = r_an | {3{w_blink_off}};
  assign high_score = r_high_score;
  assign new_record = r_new_record;

endmodule
`default_nettype wire

// File: doc/score_digit_scanner.md
Name: score_digit_scanner

Overview:
- Consumes the 3-digit packed-BCD game score from the score counter and drives a 3-digit multiplexed, common-anode seven-segment display.
- Tracks the session high score, updating it on each game-over event.
- Sits directly downstream of the score counter; its outputs go to board pins.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit (1 kHz per digit at 50 MHz); legal range 2..2^20.
- BLINK_DIV, 12500000, clk cycles per blink half-period; used only with SCORE_BLINK_EN.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- Score  in  12  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds
- game_over  in  1  level, high while the game is over
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  3  digit enables, active-low; an[0] = ones
- high_score  out  12  packed-BCD session high score
- new_record  out  1  one-cycle pulse when high_score is updated

Behaviour:
- Reset, asynchronous on resetN low:
  - seg = 7'h7F, an = 3'b111, high_score = 0, new_record = 0.
  - Refresh counter = 0, digit index = 0, shadow score = 0, game_over history = 0.
  - All outputs take these values immediately; reset mid-scan abandons the scan.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - On the terminal count, digit index advances 0→1→2→0. Index 3 is unreachable; if entered it is forced to 0.
- Shadow score:
  - Score is sampled into a shadow register on the cycle the index wraps 2→0, and once on the first terminal count after reset.
  - A whole scan shows one consistent value, with no tearing.
- Output timing:
  - seg and an are registered and change together.
  - Latency is 1 cycle from the terminal count to the new digit appearing.
  - Exactly one an bit is low at any time after the first terminal count.
- Segment decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble 10..15 shows dash 0111111.
- Leading-zero blanking:
  - Hundreds shows blank (1111111) if 0.
  - Tens shows blank if hundreds and tens are both 0.
  - Ones is never blanked.
  - Blanked digits keep their an bit low with seg = 7'h7F.
  - Dash digits are never blanked.
- Game-over edge and high score:
  - game_over is registered once; the rising edge is prev=0 and current=1.
  - On the edge, live Score is compared against high_score as a 12-bit unsigned value; for valid BCD this equals numeric order.
  - If Score > high_score and all three nibbles are ≤9: high_score <= Score the next cycle, and new_record pulses high for exactly that cycle.
  - Score equal to high_score, or any invalid nibble: no update, no pulse.
  - game_over held high produces no further edges.
- Simultaneous events: a game-over edge coinciding with a scan wrap or shadow load is handled independently; neither is delayed.

Optional Feature:
- Macro: SCORE_BLINK_EN
- Defined:
  - new_record starts a blink sequence of 8 half-periods of BLINK_DIV cycles each, beginning with an "off" half.
  - During "off" halves an is forced to 3'b111; seg is unaffected.
  - A new new_record during a sequence restarts it from the start.
  - Reset clears the blink state.
- Undefined: no blink counter or state is present; an follows the scan only.

Test Plan (REFRESH_DIV=4, BLINK_DIV=8 unless noted):
- Reset release, Score=12'h000 → an=111 and seg=7F until the first terminal count. Then an cycles 110→101→011 every 4 cycles, with seg 1000000 / 1111111 / 1111111.
- Score=12'h305 → scan shows 0010010 / 1000000 / 0110000. Score=12'h045 → hundreds blank, tens 0011001. Score=12'h0A7 → tens shows dash 0111111.
- Score changes 12'h123→12'h456 mid-scan → current scan finishes with 1,2,3 digits; new value appears only after the 2→0 wrap.
- game_over 0→1 with Score=12'h250, high_score=0 → high_score=12'h250 and a 1-cycle new_record. Holding game_over high gives no second pulse. Re-edge with Score=12'h199 → no update.
- Re-edge with Score=12'h250 (equal) or 12'h2F0 (invalid) → no update, no pulse.
- resetN low mid-scan with high_score=12'h250 → all outputs return to reset values asynchronously, before the next clk edge.
- With SCORE_BLINK_EN: new_record → an=111 for cycles 1-8, scanning for 9-16, and so on for 64 cycles total, then normal scanning. Without the macro, the same stimulus gives no blank periods.
